// File: rtl/mux_arb_defs.sv
// Shared definitions for the 4:1 mux round-robin arbiter: FSM encoding,
// requester select codes and a one-hot helper.
package mux_arb_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_U = 2'd0;
  localparam logic [1:0] SEL_V = 2'd1;
  localparam logic [1:0] SEL_W = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4to1_2bit.sv
// 2-bit wide 4:1 multiplexer used as the arbiter's data path.
module mux4to1_2bit
  import mux_arb_defs::*;
(
  input  logic [1:0] s,
  input  logic [1:0] u,
  input  logic [1:0] v,
  input  logic [1:0] w,
  input  logic [1:0] x,
  output logic [1:0] m
);

  always_comb begin
    m = u;
    case (s)
      SEL_U:   m = u;
      SEL_V:   m = v;
      SEL_W:   m = w;
      SEL_X:   m = x;
      default: m = u;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating priority pick: first asserted req bit scanning
// start, start+1, start+2, start+3 (mod 4).
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       any,
  output logic [1:0] idx
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  // Doubling the vector turns the modular scan into a plain slice.
  assign dbl = {req, req};
  assign rot = dbl[start +: 4];

  always_comb begin
    off = 2'd3;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
  end

  assign any = |req;
  assign idx = start + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-bit output channel,
// with a bounded hold time per grant and bubble-free handoff.
module mux4_rr_arbiter
  import mux_arb_defs::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  input  logic [1:0] u,
  input  logic [1:0] v,
  input  logic [1:0] w,
  input  logic [1:0] x,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       m_valid,
  output logic [1:0] m
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [3:0]    gnt_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;

  logic [1:0] sel_next;
  logic [1:0] scan_start;
  logic       rel;
  logic       win_any;
  logic [1:0] win_idx;
  logic [1:0] mux_out;

  assign sel_next   = sel_q + 2'd1;
  assign rel        = !req[sel_q] || (cnt_q == CNT_MAX);
  // While granted, the scan for the next winner begins just past the grantee.
  assign scan_start = (state_q == ST_GRANT) ? sel_next : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .start (scan_start),
    .any   (win_any),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_U;
      gnt_q   <= 4'b0000;
      ptr_q   <= SEL_U;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            state_q <= ST_GRANT;
            sel_q   <= win_idx;
            gnt_q   <= onehot4(win_idx);
            cnt_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            ptr_q <= sel_next;
            cnt_q <= '0;
            if (win_any) begin
              sel_q <= win_idx;
              gnt_q <= onehot4(win_idx);
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= 4'b0000;
              valid_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  mux4to1_2bit u_mux (
    .s (sel_q),
    .u (u),
    .v (v),
    .w (w),
    .x (x),
    .m (mux_out)
  );

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign m_valid = valid_q;
  assign m       = valid_q ? mux_out : 2'b00;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a HOLD_CYCLES=4 instance is fully
// checked, a HOLD_CYCLES=1 instance on the same inputs is checked for rotation.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       resetn;
  logic [3:0] req;
  logic [1:0] u, v, w, x;
  logic [1:0] sel, sel1;
  logic [3:0] gnt, gnt1;
  logic       m_valid, m_valid1;
  logic [1:0] m, m1;

  int errors = 0;
  int checks = 0;

  logic [1:0] data_tbl [4];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .u(u), .v(v), .w(w), .x(x),
    .sel(sel), .gnt(gnt), .m_valid(m_valid), .m(m)
  );

  mux4_rr_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .resetn(resetn), .req(req),
    .u(u), .v(v), .w(w), .x(x),
    .sel(sel1), .gnt(gnt1), .m_valid(m_valid1), .m(m1)
  );

  // Full output check of the HOLD_CYCLES=4 instance.
  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic [1:0] em);
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
    end
    checks++;
    assert (sel === es) else begin
      errors++;
      $error("FAIL %s sel got=%b exp=%b", tag, sel, es);
    end
    checks++;
    assert (m_valid === ev) else begin
      errors++;
      $error("FAIL %s m_valid got=%b exp=%b", tag, m_valid, ev);
    end
    checks++;
    assert (m === em) else begin
      errors++;
      $error("FAIL %s m got=%b exp=%b", tag, m, em);
    end
  endtask

  task automatic chk1(input string tag, input logic [3:0] eg);
    checks++;
    assert (gnt1 === eg) else begin
      errors++;
      $error("FAIL %s gnt1 got=%b exp=%b", tag, gnt1, eg);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    data_tbl[0] = 2'b01;
    data_tbl[1] = 2'b11;
    data_tbl[2] = 2'b10;
    data_tbl[3] = 2'b00;
    u = data_tbl[0];
    v = data_tbl[1];
    w = data_tbl[2];
    x = data_tbl[3];

    // 1. reset with all requesting
    resetn = 1'b0;
    req    = 4'hF;
    repeat (3) step();
    chk("reset", 4'b0000, 2'd0, 1'b0, 2'b00);
    chk1("reset_h1", 4'b0000);
    resetn = 1'b1;

    // 3. all requesting: u,v,w,x for 4 cycles each, then u again
    for (int i = 0; i < 17; i++) begin
      int g4, g1;
      step();
      g4 = (i / 4) % 4;
      g1 = i % 4;
      chk($sformatf("rr_all_%0d", i), 4'b0001 << g4, 2'(g4), 1'b1, data_tbl[g4]);
      chk1($sformatf("rr_h1_%0d", i), 4'b0001 << g1);
    end

    // 2. single requester w: re-wins on hold expiry, gnt never drops
    resetn = 1'b0;
    #1;
    chk("async_rst_a", 4'b0000, 2'd0, 1'b0, 2'b00);
    req = 4'b0100;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("solo_w_%0d", i), 4'b0100, 2'd2, 1'b1, 2'b10);
    end

    // 4. early release: v granted, drops at cnt=1, grant moves to x
    resetn = 1'b0;
    req    = 4'b1010;
    step();
    resetn = 1'b1;
    step();
    chk("early_v_c0", 4'b0010, 2'd1, 1'b1, data_tbl[1]);
    step();
    chk("early_v_c1", 4'b0010, 2'd1, 1'b1, data_tbl[1]);
    req = 4'b1000;
    step();
    chk("early_to_x", 4'b1000, 2'd3, 1'b1, data_tbl[3]);

    // 5. wrap-around: x holds 4 cycles, then grant goes to u
    req = 4'b1001;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("wrap_x_c%0d", i), 4'b1000, 2'd3, 1'b1, data_tbl[3]);
    end
    step();
    chk("wrap_to_u", 4'b0001, 2'd0, 1'b1, data_tbl[0]);

    // u drops: handoff to w with scan starting at v
    req = 4'b0100;
    step();
    chk("handoff_w", 4'b0100, 2'd2, 1'b1, data_tbl[2]);

    // 6. mid-grant asynchronous reset, then scan restarts from u
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_mid", 4'b0000, 2'd0, 1'b0, 2'b00);
    req = 4'b1111;
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_u", 4'b0001, 2'd0, 1'b1, data_tbl[0]);

    // all requests drop: one-cycle release back to idle, m gated to 00
    req = 4'b0000;
    step();
    chk("to_idle", 4'b0000, 2'd0, 1'b0, 2'b00);
    step();
    chk("stay_idle", 4'b0000, 2'd0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
